// File: rtl/oled_bus.sv
`default_nettype none
// ============================================================================
//  Module   : oled_bus
//  Purpose  : Parallel-bus transaction engine for the OLED panel. It takes one
//             command byte and an optional burst of data beats, then drives
//             the panel strobes with programmable setup/pulse/hold timing.
//  Ports    : clk, rst (async, active-high)
//             cmd_valid/cmd_ready/cmd/len[/cmd_read]  transaction request
//             data_valid/data_ready/data               write data beats
//             busy                                     engine not idle
//             oled_cs/oled_e/oled_rw/oled_dc/oled_q/oled_oe  panel pins
//             [oled_d/rd_valid/rd_data]                read path
//  Options  : OLED_READ_EN - adds the read-burst path and its ports.
//  Revision : 1.0  initial release
// ============================================================================
module oled_bus #(
    parameter int DATA_WIDTH   = 8,
    parameter int LEN_WIDTH    = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  oled_cs,
    output logic                  oled_e,
    output logic                  oled_rw,
    output logic                  oled_dc,
    output logic [DATA_WIDTH-1:0] oled_q,
    output logic                  oled_oe
`ifdef OLED_READ_EN
    ,
    input  logic                  cmd_read,
    input  logic [DATA_WIDTH-1:0] oled_d,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data
`endif
);

    localparam int C_MAX_PHASE =
        (SETUP_CYCLES > PULSE_CYCLES)
            ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
            : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
    localparam int C_PW = $clog2(C_MAX_PHASE + 1);

    localparam logic [C_PW-1:0]      C_SETUP_LAST = C_PW'(SETUP_CYCLES - 1);
    localparam logic [C_PW-1:0]      C_PULSE_LAST = C_PW'(PULSE_CYCLES - 1);
    localparam logic [C_PW-1:0]      C_HOLD_LAST  = C_PW'(HOLD_CYCLES - 1);
    localparam logic [C_PW-1:0]      C_PH_ONE     = C_PW'(1);
    localparam logic [LEN_WIDTH-1:0] C_LEN_ONE    = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_PULSE     = 3'd2,
        S_HOLD      = 3'd3,
        S_WAIT_DATA = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [C_PW-1:0]         phase_q, phase_d;
    logic [LEN_WIDTH-1:0]    rem_q,   rem_d;
    logic [DATA_WIDTH-1:0]   q_q,     q_d;
    logic                    dc_q,    dc_d;
    logic                    oe_q,    oe_d;
`ifdef OLED_READ_EN
    logic                    read_q,  read_d;     // burst direction latched at acceptance
    logic                    rbeat_q, rbeat_d;    // current beat is a read data beat (drives rw)
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            dc_q    <= 1'b0;
            oe_q    <= 1'b0;
`ifdef OLED_READ_EN
            read_q  <= 1'b0;
            rbeat_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dc_q    <= dc_d;
            oe_q    <= oe_d;
`ifdef OLED_READ_EN
            read_q  <= read_d;
            rbeat_q <= rbeat_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dc_d    = dc_q;
        oe_d    = oe_q;
`ifdef OLED_READ_EN
        read_d  = read_q;
        rbeat_d = rbeat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_SETUP;
                    phase_d = '0;
                    rem_d   = len;
                    q_d     = cmd;
                    dc_d    = 1'b0;
                    oe_d    = 1'b1;
`ifdef OLED_READ_EN
                    read_d  = cmd_read;
                    rbeat_d = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (phase_q == C_SETUP_LAST) begin
                    state_d = S_PULSE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + C_PH_ONE;
                end
            end
            S_PULSE: begin
                if (phase_q == C_PULSE_LAST) begin
                    state_d = S_HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + C_PH_ONE;
                end
            end
            S_HOLD: begin
                if (phase_q == C_HOLD_LAST) begin
                    phase_d = '0;
                    if (rem_q == '0) begin
                        state_d = S_DONE;
                        dc_d    = 1'b0;
                        oe_d    = 1'b0;
`ifdef OLED_READ_EN
                        rbeat_d = 1'b0;
                    end else if (read_q) begin
                        // Read beats skip WAIT_DATA: release the bus and strobe again.
                        state_d = S_SETUP;
                        rem_d   = rem_q - C_LEN_ONE;
                        dc_d    = 1'b1;
                        oe_d    = 1'b0;
                        rbeat_d = 1'b1;
`endif
                    end else begin
                        state_d = S_WAIT_DATA;
                    end
                end else begin
                    phase_d = phase_q + C_PH_ONE;
                end
            end
            S_WAIT_DATA: begin
                if (data_valid) begin
                    state_d = S_SETUP;
                    q_d     = data;
                    dc_d    = 1'b1;
                    if (rem_q != '0) begin
                        rem_d = rem_q - C_LEN_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef OLED_READ_EN
    // Panel data is captured on the last low cycle of E and presented on the first HOLD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (state_q == S_PULSE && phase_q == C_PULSE_LAST && rbeat_q) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= oled_d;
            end
        end
    end
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign oled_rw  = rbeat_q;
`else
    assign oled_rw  = 1'b0;
`endif

    // Strobes decode straight from state so an async reset takes effect at once.
    assign cmd_ready  = (state_q == S_IDLE);
    assign data_ready = (state_q == S_WAIT_DATA);
    assign busy       = (state_q != S_IDLE);
    assign oled_cs    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign oled_e     = (state_q != S_PULSE);
    assign oled_dc    = dc_q;
    assign oled_q     = q_q;
    assign oled_oe    = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oled_bus
//  Purpose  : Self-checking bench for oled_bus. Two instances (default timing
//             and SETUP=2/PULSE=4/HOLD=1) are driven from a cycle-level
//             reference timeline built from the transaction rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_oled_bus;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cv, dv, crd;
    logic [7:0] cmd_s [2];
    logic [7:0] len_s [2];
    logic [7:0] dat_s [2];
    logic [7:0] od_s  [2];
    logic [1:0] rdy_w, drdy_w, busy_w, cs_w, e_w, rw_w, dc_w, oe_w, rdv_w;
    logic [7:0] q_w   [2];
    logic [7:0] rdd_w [2];

    always #5 clk = ~clk;

    oled_bus u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(rdy_w[0]),
        .cmd(cmd_s[0]), .len(len_s[0]), .data_valid(dv[0]), .data_ready(drdy_w[0]),
        .data(dat_s[0]), .busy(busy_w[0]), .oled_cs(cs_w[0]), .oled_e(e_w[0]),
        .oled_rw(rw_w[0]), .oled_dc(dc_w[0]), .oled_q(q_w[0]), .oled_oe(oe_w[0])
`ifdef OLED_READ_EN
        , .cmd_read(crd[0]), .oled_d(od_s[0]), .rd_valid(rdv_w[0]), .rd_data(rdd_w[0])
`endif
    );

    oled_bus #(.SETUP_CYCLES(2), .PULSE_CYCLES(4), .HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(rdy_w[1]),
        .cmd(cmd_s[1]), .len(len_s[1]), .data_valid(dv[1]), .data_ready(drdy_w[1]),
        .data(dat_s[1]), .busy(busy_w[1]), .oled_cs(cs_w[1]), .oled_e(e_w[1]),
        .oled_rw(rw_w[1]), .oled_dc(dc_w[1]), .oled_q(q_w[1]), .oled_oe(oe_w[1])
`ifdef OLED_READ_EN
        , .cmd_read(crd[1]), .oled_d(od_s[1]), .rd_valid(rdv_w[1]), .rd_data(rdd_w[1])
`endif
    );

`ifndef OLED_READ_EN
    assign rdv_w    = 2'b00;
    assign rdd_w[0] = 8'h00;
    assign rdd_w[1] = 8'h00;
`endif

    // One expected cycle: pin/handshake flags, bus value, and inputs to apply.
    typedef struct packed {
        logic [8:0] fl;   // {rd_valid, cs, e, rw, dc, oe, cmd_ready, data_ready, busy}
        logic [7:0] q;
        logic       cv;
        logic [7:0] cmd;
        logic [7:0] len;
        logic       crd;
        logic       dv;
        logic [7:0] dat;
    } cyc_t;

    cyc_t       exp_q [$];
    logic [7:0] last_q [2];
    logic [7:0] exp_rd [2];
    logic [7:0] bdat [16];
    int         bst  [16];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [8:0] mk(input logic rdv, cs, e, rw, dc, oe, rdy, drdy, bsy);
        return {rdv, cs, e, rw, dc, oe, rdy, drdy, bsy};
    endfunction

    function automatic logic [8:0] obs_fl(input int sel);
        return {rdv_w[sel], cs_w[sel], e_w[sel], rw_w[sel], dc_w[sel], oe_w[sel],
                rdy_w[sel], drdy_w[sel], busy_w[sel]};
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    // Cycles where cmd_valid/data_valid are irrelevant get random junk on them.
    task automatic push(input logic [8:0] fl, input logic [7:0] q, input logic c_v,
                        input logic [7:0] c, input logic [7:0] l, input logic r,
                        input logic d_v, input logic [7:0] d);
        cyc_t e;
        e.fl = fl; e.q = q; e.cv = c_v; e.cmd = c; e.len = l; e.crd = r; e.dv = d_v; e.dat = d;
        exp_q.push_back(e);
    endtask

    task automatic push_busy(input logic [8:0] fl, input logic [7:0] q);
        push(fl, q, 1'($urandom), rnd8(), rnd8(), 1'($urandom), 1'($urandom), rnd8());
    endtask

    task automatic push_idle(input int sel);
        push(mk(0,1,1,0,0,0,1,0,0), last_q[sel], 1'b0, rnd8(), rnd8(), 1'($urandom),
             1'($urandom), rnd8());
    endtask

    // Expected timeline of one transaction, from the accepting IDLE cycle to DONE.
    task automatic build(input int sel, input int S, input int P, input int H,
                         input logic [7:0] cmd, input int len, input logic rd);
        logic [7:0] lq;
        logic       ld, lr, lo;
        push(mk(0,1,1,0,0,0,1,0,0), last_q[sel], 1'b1, cmd, 8'(len), rd,
             1'($urandom), rnd8());
        lq = cmd; ld = 1'b0; lr = 1'b0; lo = 1'b1;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) begin
                if (rd) begin
                    ld = 1'b1; lr = 1'b1; lo = 1'b0;
                end else begin
                    for (int w = 0; w <= bst[k]; w++) begin
                        push(mk(0,0,1,0,ld,1,0,1,1), lq, 1'($urandom), rnd8(), rnd8(),
                             1'($urandom), (w == bst[k]), (w == bst[k]) ? bdat[k] : rnd8());
                    end
                    lq = bdat[k]; ld = 1'b1;
                end
            end
            for (int i = 0; i < S; i++) push_busy(mk(0,0,1,lr,ld,lo,0,0,1), lq);
            for (int i = 0; i < P; i++) push_busy(mk(0,0,0,lr,ld,lo,0,0,1), lq);
            for (int i = 0; i < H; i++) push_busy(mk((i == 0) && lr,0,1,lr,ld,lo,0,0,1), lq);
        end
        push_busy(mk(0,1,1,0,0,0,0,0,1), lq);
        last_q[sel] = lq;
    endtask

    // Apply n expected cycles (all when n < 0); entered and left at posedge+1.
    task automatic run(input int sel, input int n);
        cyc_t c;
        int   cnt;
        cnt = 0;
        while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
            c = exp_q.pop_front();
            cv = '0; dv = '0; crd = '0;
            cv[sel] = c.cv; dv[sel] = c.dv; crd[sel] = c.crd;
            cmd_s[sel] = c.cmd; len_s[sel] = c.len; dat_s[sel] = c.dat;
            @(negedge clk);
            check("flags", 32'(obs_fl(sel)), 32'(c.fl));
            check("q", 32'(q_w[sel]), 32'(c.q));
            if (c.fl[8]) check("rd_data", 32'(rdd_w[sel]), 32'(exp_rd[sel]));
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int sel, len, gap;
        rst = 1'b1; cv = '0; dv = '0; crd = '0;
        for (int i = 0; i < 2; i++) begin
            cmd_s[i] = '0; len_s[i] = '0; dat_s[i] = '0; od_s[i] = '0;
            last_q[i] = '0; exp_rd[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin bdat[i] = '0; bst[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_flags", 32'(obs_fl(i)), 32'(mk(0,1,1,0,0,0,1,0,0)));
            check("reset_q", 32'(q_w[i]), 32'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Command only, default timing.
        build(0, 1, 2, 1, 8'hAF, 0, 1'b0); run(0, -1);
        // Two-beat write burst, data_valid always ready.
        bdat[1] = 8'h00; bdat[2] = 8'h7F; bst[1] = 0; bst[2] = 0;
        push_idle(0);
        build(0, 1, 2, 1, 8'h15, 2, 1'b0); run(0, -1);
        // Same burst with the second beat withheld for 10 data_ready cycles.
        bst[2] = 9;
        build(0, 1, 2, 1, 8'h15, 2, 1'b0); run(0, -1);
        // Long pulse / long setup instance.
        build(1, 2, 4, 1, 8'h81, 0, 1'b0); run(1, -1);

        // Randomized transactions on both instances.
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(0, 1);
            len = $urandom_range(0, 3);
            gap = $urandom_range(0, 2);
            for (int k = 0; k < 16; k++) begin
                bdat[k] = rnd8();
                bst[k]  = $urandom_range(0, 3);
            end
            for (int g = 0; g < gap; g++) push_idle(sel);
            if (sel == 1) build(1, 2, 4, 1, rnd8(), len, 1'b0);
            else          build(0, 1, 2, 1, rnd8(), len, 1'b0);
            run(sel, -1);
        end

        // Asynchronous reset in the second PULSE cycle of a burst.
        bst[1] = 0; bst[2] = 0; bdat[1] = 8'h11; bdat[2] = 8'h22;
        build(0, 1, 2, 1, 8'h15, 2, 1'b0);
        run(0, 3);
        cv = '0; dv = '0;
        @(negedge clk);
        check("pre_rst_e", 32'(e_w[0]), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_flags", 32'(obs_fl(0)), 32'(mk(0,1,1,0,0,0,1,0,0)));
        check("rst_mid_q", 32'(q_w[0]), 32'h0);
        exp_q.delete();
        last_q[0] = '0; last_q[1] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(rdy_w[0]), 32'h1);
        bdat[1] = 8'h3C; bst[1] = 1;
        build(0, 1, 2, 1, 8'hA5, 1, 1'b0); run(0, -1);

`ifdef OLED_READ_EN
        // Read burst: one beat, panel drives 0x5A.
        od_s[0] = 8'h5A; exp_rd[0] = 8'h5A;
        push_idle(0);
        build(0, 1, 2, 1, 8'hB0, 1, 1'b1); run(0, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oled_bus.md
# oled_bus

Parametrised parallel-bus transaction engine for the OLED display panel. It accepts one command byte plus an optional burst of data beats over a valid/ready interface. It drives the panel's CS/E/RW/DC strobes and data bus with programmable setup, pulse and hold timing. It sits between the display-refresh logic and the OLED pins.

## Interface
- DATA_WIDTH, 8: panel data bus width.
- LEN_WIDTH, 8: width of burst length field; max burst 2^LEN_WIDTH-1 data beats.
- SETUP_CYCLES, 1: cycles E stays high with DC/RW/data valid before the strobe; ≥1.
- PULSE_CYCLES, 2: cycles E is held low; ≥1.
- HOLD_CYCLES, 1: cycles data/DC held after E rises; ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  transaction request.
- cmd_ready  out  1  high in IDLE only.
- cmd  in  DATA_WIDTH  command byte.
- len  in  LEN_WIDTH  data beats following the command; 0 = command only.
- cmd_read  in  1  read burst (OLED_READ_EN only; ignored otherwise).
- data_valid  in  1  write data beat available.
- data_ready  out  1  high in WAIT_DATA on write bursts.
- data  in  DATA_WIDTH  write data beat.
- busy  out  1  high whenever state ≠ IDLE.
- oled_cs  out  1  chip select, active-low.
- oled_e  out  1  strobe; idles high, panel latches on rising edge.
- oled_rw  out  1  0 write, 1 read.
- oled_dc  out  1  0 command, 1 data.
- oled_q  out  DATA_WIDTH  bus output data.
- oled_oe  out  1  bus output enable for pad tristate.
- oled_d  in  DATA_WIDTH  bus input (OLED_READ_EN only).
- rd_valid  out  1  one-cycle read-beat pulse (OLED_READ_EN only).
- rd_data  out  DATA_WIDTH  read beat (OLED_READ_EN only).

## Operation
- States: IDLE, SETUP, PULSE, HOLD, WAIT_DATA, DONE.
- Reset values: cs=1, e=1, rw=0, dc=0, q=0, oe=0, cmd_ready=1, data_ready=0, busy=0, rd_valid=0, rd_data=0. State → IDLE.
- IDLE: cmd_valid&&cmd_ready accepts the transaction. It latches cmd, len and cmd_read into a remaining-beat counter, then goes to SETUP. In SETUP: cs=0, dc=0, rw=0, oe=1, q=cmd.
- SETUP: e=1 for SETUP_CYCLES, then PULSE. PULSE: e=0 for PULSE_CYCLES, then HOLD. HOLD: e=1, q/dc/rw unchanged for HOLD_CYCLES.
- After HOLD: remaining=0 → DONE. Otherwise a write burst → WAIT_DATA; a read burst → SETUP directly, with dc=1, rw=1, oe=0.
- WAIT_DATA: data_ready=1, cs stays 0, e=1. When data_valid is high, the beat is accepted: q=data, dc=1, remaining decrements, next state SETUP. data_valid outside WAIT_DATA is ignored.
- DONE: cs=1, e=1, oe=0, dc=0, rw=0 for one cycle, then IDLE.
- cmd_valid while busy is ignored. cmd/len are sampled only at acceptance.
- Phase counter width is $clog2(max(SETUP,PULSE,HOLD)+1). The remaining counter is LEN_WIDTH bits and never wraps: it decrements only when nonzero.
- Async rst mid-transaction: all outputs return to reset values immediately. No partial strobe completes, and the pending burst is dropped.

## Timing
- Beat length B = SETUP_CYCLES+PULSE_CYCLES+HOLD_CYCLES cycles (default 4).
- Command-only transaction:
  - Acceptance at edge T0.
  - cs low T1..TB.
  - DONE at TB+1.
  - cmd_ready high again at TB+2, so cmd_ready is low B+1 cycles.
- Write data beat: 1 WAIT_DATA cycle minimum plus B cycles. data_valid held high means zero stall.
- Read data beat: B cycles with no WAIT_DATA.
- Minimum cs-high gap between transactions: 2 cycles (DONE + IDLE).
- E low width is exactly PULSE_CYCLES. Data is stable SETUP_CYCLES before E falls and HOLD_CYCLES after E rises.

## Configuration
- OLED_READ_EN defined:
  - cmd_read, oled_d, rd_valid and rd_data exist.
  - In a read burst, oled_d is sampled in the last PULSE cycle.
  - rd_data is updated and rd_valid pulses for one cycle on the first HOLD cycle.
- OLED_READ_EN undefined:
  - Read ports are absent and all bursts are writes.
  - rw is constant 0.

## Test plan
- Defaults, cmd=0xAF len=0 → cs low exactly 4 cycles, q=0xAF, dc=0, e low 2 cycles, cmd_ready low 5 cycles.
- cmd=0x15 len=2, data 0x00 then 0x7F, data_valid held high:
  - cs low 14 contiguous cycles.
  - Three E pulses, dc=0 then 1, 1.
  - q sequence 0x15, 0x00, 0x7F.
  - data_ready high one cycle per data beat.
- Same burst with data_valid withheld 10 cycles before the second beat → cs stays low, e stays 1, data_ready high 10 cycles, then the beat completes with q=0x7F.
- rst asserted during the second PULSE cycle of a burst → same cycle: cs=1, e=1, oe=0, busy=0; next cycle cmd_ready=1, and a new command runs cleanly.
- PULSE_CYCLES=4, SETUP_CYCLES=2 with cmd=0x81 len=0 → e low exactly 4 cycles, preceded by 2 cycles with q=0x81.
- OLED_READ_EN, cmd=0xB0 cmd_read=1 len=1, oled_d=0x5A → data beat has rw=1, oe=0, dc=1; one rd_valid pulse with rd_data=0x5A.
